// File: rtl/uart_pkg.sv
// Shared definitions for the fifo-fed UART transmitter.
//   state_e : transmitter FSM states
//   LINE_*  : serial line levels for idle, start and stop
//   cnt_w() : counter width for a modulus, never less than one bit
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and wraps, pulsing tick on the last count.
// Ports:
//   clk_i   : system clock, rising edge
//   rst_i   : synchronous reset, active-high
//   clear_i : hold the count at 0 (used while no bit is on the line)
//   tick_o  : high on the final cycle of each serial bit
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed directly from a synchronous fifo with registered dout.
// Each byte is sent as start bit, data LSB first, optional parity, stop bit(s).
// Ports:
//   clk_i, rst_i   : clock and synchronous active-high reset
//   enable_i       : permits new frames to start (a running frame always completes)
//   fifo_empty_i   : fifo empty flag, looked at only in IDLE
//   fifo_dout_i    : fifo read data, used only in FETCH
//   fifo_rd_en_o   : one-cycle read strobe per frame
//   tx_o           : registered serial line, idle high
//   busy_o         : high from FETCH through the last stop-bit cycle
//   frame_done_o   : pulse on the final cycle of the last stop bit
//   state_o        : current FSM state, for observation
//
// Fifo handshake: fifo_rd_en_o is a strobe, high for exactly one cycle when the
// transmitter is IDLE, enabled, not in reset and the fifo is not empty; the fifo
// presents the popped word on fifo_dout_i during the following cycle (FETCH),
// which is the only cycle the data is captured. There is no line-side backpressure.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_dout_i,
  output logic             fifo_rd_en_o,
  output logic             tx_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic [2:0]       state_o
);

  // One index counter serves both the data bits and the stop bits.
  localparam int IDX_W = cnt_w((WIDTH > STOP_BITS) ? WIDTH : STOP_BITS);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               par_q, par_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               tx_q, tx_d;
  logic               baud_clear;
  logic               baud_tick;

  assign fifo_rd_en_o = (state_q == IDLE) && enable_i && !fifo_empty_i && !rst_i;

  // The bit timer only runs while a bit is actually on the line.
  assign baud_clear = (state_q == IDLE) || (state_q == FETCH);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (baud_clear),
    .tick_o  (baud_tick)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      par_q   <= 1'b0;
      idx_q   <= '0;
      tx_q    <= LINE_IDLE;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      par_q   <= par_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    par_d   = par_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (fifo_rd_en_o) state_d = FETCH;
      end
      FETCH: begin
        data_d  = fifo_dout_i;
        par_d   = (^fifo_dout_i) ^ (PARITY_ODD != 0);
        idx_d   = '0;
        state_d = START;
      end
      START: begin
        if (baud_tick) state_d = DATA;
      end
      DATA: begin
        if (baud_tick) begin
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_tick) state_d = STOP;
      end
      STOP: begin
        if (baud_tick) begin
          if (idx_q == LAST_STOP) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. The line level is chosen from the state being entered so
  // that the registered tx changes on the same edge as the state.
  always_comb begin
    tx_d = LINE_IDLE;
    case (state_d)
      START:   tx_d = LINE_START;
      DATA:    tx_d = data_d[idx_d];
      PARITY:  tx_d = par_d;
      STOP:    tx_d = LINE_STOP;
      default: tx_d = LINE_IDLE;
    endcase
  end

  assign tx_o         = tx_q;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = (state_q == STOP) && baud_tick && (idx_q == LAST_STOP);
  assign state_o      = state_q;

endmodule
